// File: rtl/cache_line_ram_1r1w_pkg.sv
// Shared defaults, state encoding and line-width helper for the 1R1W cache line store.
package cache_ram_pkg;

  localparam int unsigned NL_DEF  = 256;
  localparam int unsigned LSS_DEF = 8;
  localparam int unsigned WW_DEF  = 32;
  localparam int unsigned WPL_DEF = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  function automatic int unsigned line_width(input int unsigned wpl, input int unsigned ww);
    return wpl * ww;
  endfunction

endpackage

// File: rtl/cache_line_ram_1r1w_if.sv
// Read/write/clear port bundle of the cache line store; the controller drives master.
interface cache_line_ram_1r1w_if
  import cache_ram_pkg::*;
#(
  parameter int unsigned LSS = LSS_DEF,
  parameter int unsigned WW  = WW_DEF,
  parameter int unsigned WPL = WPL_DEF
);

  localparam int unsigned LW = line_width(WPL, WW);

  logic           rd_en;
  logic [LSS-1:0] rd_sel;
  logic [LW-1:0]  rd_data;
  logic           rd_valid;
  logic [LSS-1:0] wr_sel;
  logic [LW-1:0]  wr_data;
  logic [WPL-1:0] wr_wen;
  logic           clr_req;
  logic           ready;

  modport master (
    output rd_en, rd_sel, wr_sel, wr_data, wr_wen, clr_req,
    input  rd_data, rd_valid, ready
  );

  modport slave (
    input  rd_en, rd_sel, wr_sel, wr_data, wr_wen, clr_req,
    output rd_data, rd_valid, ready
  );

endinterface

// File: rtl/cache_line_ram_1r1w_bank.sv
// One word-wide bank: NL x WW storage, synchronous write, registered read with read enable.
module ram_bank_1r1w #(
  parameter int unsigned NL  = 256,
  parameter int unsigned LSS = 8,
  parameter int unsigned WW  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic [LSS-1:0] waddr,
  input  logic [WW-1:0]  wdata,
  input  logic           re,
  input  logic [LSS-1:0] raddr,
  output logic [WW-1:0]  rdata
);

  logic [WW-1:0] mem_q [NL];
  logic [WW-1:0] rdata_q;
  logic [WW-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read returns pre-write contents on a same-edge collision; the top forwards.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cache_line_ram_1r1w.sv
// Parametrised 1R1W cache line store: WPL word banks, clear sweep engine,
// and write-first forwarding of same-edge collisions on the read port.
module cache_line_ram_1r1w
  import cache_ram_pkg::*;
#(
  parameter int unsigned NL  = NL_DEF,
  parameter int unsigned LSS = LSS_DEF,
  parameter int unsigned WW  = WW_DEF,
  parameter int unsigned WPL = WPL_DEF
) (
  input logic                  nGCLK,
  input logic                  nRESET,
  cache_line_ram_1r1w_if.slave bus
);

  localparam int unsigned LW = line_width(WPL, WW);

  if (NL != (32'd1 << LSS)) begin : g_bad_depth
    $error("cache_line_ram_1r1w: NL must equal 2**LSS");
  end

  state_e         state_q, state_d;
  logic [LSS-1:0] cnt_q, cnt_d;
  logic           ready_q, ready_d;
  logic           rd_valid_q, rd_valid_d;
  logic           fwd_hit_q, fwd_hit_d;
  logic [WPL-1:0] fwd_wen_q, fwd_wen_d;
  logic [LW-1:0]  fwd_data_q, fwd_data_d;

  logic           rd_acc;
  logic           wr_acc;
  logic           clearing;
  logic [WPL-1:0] bank_we;
  logic [LSS-1:0] bank_waddr;
  logic [LW-1:0]  bank_wdata;
  logic [LW-1:0]  bank_rdata;
  logic [LW-1:0]  rd_data_c;

  // Sweep/idle control plus capture of collision info for the read being accepted.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_acc     = 1'b0;
    wr_acc     = 1'b0;
    fwd_hit_d  = fwd_hit_q;
    fwd_wen_d  = fwd_wen_q;
    fwd_data_d = fwd_data_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + LSS'(1);
        if (cnt_q == LSS'(NL - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        rd_acc = bus.rd_en;
        wr_acc = |bus.wr_wen;
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
    if (rd_acc) begin
      fwd_hit_d  = wr_acc && (bus.rd_sel == bus.wr_sel);
      fwd_wen_d  = bus.wr_wen;
      fwd_data_d = bus.wr_data;
    end
    rd_valid_d = rd_acc;
    ready_d    = (state_d == IDLE);
  end

  always_ff @(posedge nGCLK) begin
    if (!nRESET) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_wen_q  <= '0;
      fwd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_wen_q  <= fwd_wen_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // Write port: clear engine owns the banks during the sweep.
  always_comb begin
    clearing   = (state_q == CLEAR);
    bank_waddr = clearing ? cnt_q : bus.wr_sel;
    bank_wdata = clearing ? '0 : bus.wr_data;
    for (int i = 0; i < int'(WPL); i++) begin
      bank_we[i] = clearing | (wr_acc & bus.wr_wen[i]);
    end
  end

  for (genvar g = 0; g < int'(WPL); g++) begin : g_bank
    ram_bank_1r1w #(
      .NL (NL),
      .LSS(LSS),
      .WW (WW)
    ) u_bank (
      .clk  (nGCLK),
      .rst_n(nRESET),
      .we   (bank_we[g]),
      .waddr(bank_waddr),
      .wdata(bank_wdata[g*WW +: WW]),
      .re   (rd_acc),
      .raddr(bus.rd_sel),
      .rdata(bank_rdata[g*WW +: WW])
    );
  end

  always_comb begin
    rd_data_c = bank_rdata;
    for (int i = 0; i < int'(WPL); i++) begin
      if (fwd_hit_q && fwd_wen_q[i]) begin
        rd_data_c[i*WW +: WW] = fwd_data_q[i*WW +: WW];
      end
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_valid = rd_valid_q;
  assign bus.ready    = ready_q;

endmodule

// File: tb/tb_cache_line_ram_1r1w.sv
// Directed bench for cache_line_ram_1r1w: sweep timing, reads, writes, collisions, clear, reset.
module tb_cache_line_ram_1r1w;

  localparam int unsigned LSS = 8;
  localparam int unsigned WW  = 32;
  localparam int unsigned WPL = 8;
  localparam int unsigned LW  = WPL * WW;

  logic nGCLK;
  logic nRESET;
  int   checks;
  int   failures;

  logic [LW-1:0] exp_line;
  logic [LW-1:0] line7;
  logic [LW-1:0] line9;
  logic [LW-1:0] pat_a5;
  logic [LW-1:0] pat_beef;

  cache_line_ram_1r1w_if #(.LSS(LSS), .WW(WW), .WPL(WPL)) bus_if ();

  cache_line_ram_1r1w #(
    .NL (256),
    .LSS(LSS),
    .WW (WW),
    .WPL(WPL)
  ) dut (
    .nGCLK (nGCLK),
    .nRESET(nRESET),
    .bus   (bus_if)
  );

  initial nGCLK = 1'b0;
  always #5 nGCLK = ~nGCLK;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge nGCLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.rd_en   = 1'b0;
    bus_if.rd_sel  = '0;
    bus_if.wr_sel  = '0;
    bus_if.wr_data = '0;
    bus_if.wr_wen  = '0;
    bus_if.clr_req = 1'b0;
  endtask

  task automatic write_line(input logic [LSS-1:0] sel, input logic [LW-1:0] data);
    bus_if.wr_sel  = sel;
    bus_if.wr_data = data;
    bus_if.wr_wen  = '1;
    tick(1);
    bus_if.wr_wen  = '0;
  endtask

  task automatic read_expect(input string tag, input logic [LSS-1:0] sel, input logic [LW-1:0] exp);
    bus_if.rd_en  = 1'b1;
    bus_if.rd_sel = sel;
    tick(1);
    bus_if.rd_en  = 1'b0;
    check({tag, "_valid"}, LW'(bus_if.rd_valid), LW'(1'b1));
    check(tag, bus_if.rd_data, exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < int'(WPL); i++) begin
      pat_a5[i*WW +: WW]   = 32'hA5A5_A5A5;
      line7[i*WW +: WW]    = 32'(i);
      line9[i*WW +: WW]    = 32'h9000_0000 + 32'(i);
      pat_beef[i*WW +: WW] = 32'hBEEF_0000 + 32'(i);
    end
    idle_inputs();
    nRESET = 1'b0;
    tick(3);
    check("rst_rd_data", bus_if.rd_data, '0);
    check("rst_rd_valid", LW'(bus_if.rd_valid), '0);
    check("rst_ready", LW'(bus_if.ready), '0);

    // Initial sweep: 256 clear edges after release.
    nRESET = 1'b1;
    tick(255);
    check("sweep_ready_low_255", LW'(bus_if.ready), '0);
    tick(1);
    check("sweep_ready_high_256", LW'(bus_if.ready), LW'(1'b1));

    read_expect("rd_line0", 8'd0, '0);
    read_expect("rd_line128", 8'd128, '0);
    read_expect("rd_line255", 8'd255, '0);

    // Full write then read, with a disabled write to the same line on the read edge.
    write_line(8'd3, pat_a5);
    bus_if.wr_sel  = 8'd3;
    bus_if.wr_data = {WPL{32'h5A5A_5A5A}};
    bus_if.wr_wen  = '0;
    read_expect("rd_line3", 8'd3, pat_a5);
    bus_if.wr_data = '0;
    tick(1);
    check("idle_rd_valid", LW'(bus_if.rd_valid), '0);
    check("idle_rd_hold", bus_if.rd_data, pat_a5);

    // Partial-word collision on line 7: words 0 and 2 forwarded.
    write_line(8'd7, line7);
    bus_if.wr_sel  = 8'd7;
    bus_if.wr_data = '1;
    bus_if.wr_wen  = 8'b0000_0101;
    exp_line = line7;
    exp_line[0*WW +: WW] = 32'hFFFF_FFFF;
    exp_line[2*WW +: WW] = 32'hFFFF_FFFF;
    read_expect("coll_line7", 8'd7, exp_line);
    bus_if.wr_wen  = '0;
    tick(1);
    check("coll_hold", bus_if.rd_data, exp_line);
    read_expect("rd_line7_after", 8'd7, exp_line);

    // Independent read of line 9 and write of line 10 on the same edge.
    write_line(8'd9, line9);
    bus_if.wr_sel  = 8'd10;
    bus_if.wr_data = pat_beef;
    bus_if.wr_wen  = '1;
    read_expect("diff_rd_line9", 8'd9, line9);
    bus_if.wr_wen  = '0;
    read_expect("rd_line10_new", 8'd10, pat_beef);

    // Clear request; user traffic during the sweep must be ignored.
    bus_if.clr_req = 1'b1;
    tick(1);
    bus_if.clr_req = 1'b0;
    check("clr_ready_low", LW'(bus_if.ready), '0);
    bus_if.wr_sel  = 8'd3;
    bus_if.wr_data = {WPL{32'h1234_5678}};
    bus_if.wr_wen  = '1;
    bus_if.rd_en   = 1'b1;
    bus_if.rd_sel  = 8'd3;
    tick(255);
    check("clr_ready_low_255", LW'(bus_if.ready), '0);
    check("clr_rd_valid", LW'(bus_if.rd_valid), '0);
    check("clr_rd_hold", bus_if.rd_data, pat_beef);
    tick(1);
    check("clr_ready_high_256", LW'(bus_if.ready), LW'(1'b1));
    idle_inputs();
    read_expect("clr_line3", 8'd3, '0);
    read_expect("clr_line7", 8'd7, '0);
    read_expect("clr_line9", 8'd9, '0);
    read_expect("clr_line10", 8'd10, '0);

    // Reset mid-sweep restarts the counter.
    write_line(8'd5, pat_a5);
    nRESET = 1'b0;
    tick(1);
    check("rst2_ready", LW'(bus_if.ready), '0);
    check("rst2_rd_data", bus_if.rd_data, '0);
    nRESET = 1'b1;
    tick(100);
    nRESET = 1'b0;
    tick(1);
    nRESET = 1'b1;
    tick(255);
    check("rst3_ready_low_255", LW'(bus_if.ready), '0);
    tick(1);
    check("rst3_ready_high_256", LW'(bus_if.ready), LW'(1'b1));
    read_expect("rst3_line5", 8'd5, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
